// File: rtl/bubsys_framecap.sv
// Video frame capture: windowed pixel grab into a small FIFO, serialized as an
// 8-bit AXI-Stream-style byte stream with start-of-frame and end-of-line flags.
module bubsys_framecap #(
  parameter int unsigned H_FIRST    = 278,
  parameter int unsigned H_LAST     = 149,
  parameter int unsigned V_FIRST    = 272,
  parameter int unsigned V_LAST     = 495,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned EXPAND     = 1
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_HCOUNTER,
  input  logic [8:0]  i_VCOUNTER,
  input  logic [15:0] i_VIDEODATA,
  input  logic        i_CAP_ARM,
  input  logic        i_CAP_CONT,
  output logic [7:0]  o_TDATA,
  output logic        o_TVALID,
  input  logic        i_TREADY,
  output logic        o_TUSER,
  output logic        o_TLAST,
  output logic        o_BUSY,
  output logic        o_OVERFLOW,
  output logic [15:0] o_FRAMECNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [8:0] HFirst = 9'(H_FIRST);
  localparam logic [8:0] HLast  = 9'(H_LAST);
  localparam logic [8:0] VFirst = 9'(V_FIRST);
  localparam logic [8:0] VLast  = 9'(V_LAST);
  localparam logic [AW:0] CountFull = (AW + 1)'(FIFO_DEPTH);
  localparam logic [1:0] LastIdx = (EXPAND != 0) ? 2'd2 : 2'd1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitSof = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDrain   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic          overflow_q;
  logic [15:0]   framecnt_q;
  logic          ser_valid_q;
  logic [1:0]    ser_idx_q;
  logic [16:0]   ser_ent_q;

  logic h_in, v_in, pix_ok, is_sof, is_end;
  logic push_req, push, drop, pop, ser_final, ser_free, drain_done;
  logic [16:0] wr_ent;
  logic [7:0]  ser_byte;

  // The horizontal window may wrap through the end of the line (511 -> 128).
  assign h_in = (H_FIRST <= H_LAST) ? (i_HCOUNTER >= HFirst && i_HCOUNTER <= HLast)
                                    : (i_HCOUNTER >= HFirst || i_HCOUNTER <= HLast);
  assign v_in   = (i_VCOUNTER >= VFirst) && (i_VCOUNTER <= VLast);
  assign pix_ok = !i_EMU_CLK6MPCEN_n && h_in && v_in;
  assign is_sof = pix_ok && (i_VCOUNTER == VFirst) && (i_HCOUNTER == HFirst);
  assign is_end = pix_ok && (i_VCOUNTER == VLast) && (i_HCOUNTER == HLast);

  assign push_req = ((state_q == StWaitSof) && is_sof) || ((state_q == StCapture) && pix_ok);
  // Fullness uses the pre-cycle count, so a same-cycle pop never rescues a push.
  assign push   = push_req && (count_q != CountFull);
  assign drop   = push_req && (count_q == CountFull);
  assign wr_ent = {i_HCOUNTER == HLast, state_q == StWaitSof, i_VIDEODATA[14:0]};

  assign ser_final  = (ser_idx_q == LastIdx);
  assign ser_free   = !ser_valid_q || (i_TREADY && ser_final);
  assign pop        = (count_q != '0) && ser_free;
  assign drain_done = (state_q == StDrain) && (count_q == '0) && ser_free;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (i_CAP_ARM) state_d = StWaitSof;
      StWaitSof: if (is_sof) state_d = is_end ? StDrain : StCapture;
      StCapture: if (is_end) state_d = StDrain;
      StDrain:   if (drain_done) state_d = i_CAP_CONT ? StWaitSof : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_ent;
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      framecnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if ((state_q == StIdle) && i_CAP_ARM) overflow_q <= 1'b0;
      else if (drop)                        overflow_q <= 1'b1;
      if (drain_done) framecnt_q <= framecnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      ser_valid_q <= 1'b0;
      ser_idx_q   <= 2'd0;
      ser_ent_q   <= '0;
    end else if (pop) begin
      ser_valid_q <= 1'b1;
      ser_idx_q   <= 2'd0;
      ser_ent_q   <= fifo_mem[rd_ptr_q];
    end else if (ser_valid_q && i_TREADY) begin
      if (ser_final) ser_valid_q <= 1'b0;
      else           ser_idx_q   <= ser_idx_q + 2'd1;
    end
  end

  // Entry layout: {eol, sof, B[14:10], G[9:5], R[4:0]}.
  always_comb begin
    ser_byte = 8'h00;
    if (EXPAND != 0) begin
      unique case (ser_idx_q)
        2'd0:    ser_byte = {ser_ent_q[14:10], ser_ent_q[14:12]};
        2'd1:    ser_byte = {ser_ent_q[9:5], ser_ent_q[9:7]};
        default: ser_byte = {ser_ent_q[4:0], ser_ent_q[4:2]};
      endcase
    end else begin
      ser_byte = (ser_idx_q == 2'd0) ? ser_ent_q[7:0] : {1'b0, ser_ent_q[14:8]};
    end
  end

  assign o_TVALID   = ser_valid_q;
  assign o_TDATA    = ser_valid_q ? ser_byte : 8'h00;
  assign o_TUSER    = ser_valid_q && (ser_idx_q == 2'd0) && ser_ent_q[15];
  assign o_TLAST    = ser_valid_q && ser_final && ser_ent_q[16];
  assign o_BUSY     = (state_q != StIdle);
  assign o_OVERFLOW = overflow_q;
  assign o_FRAMECNT = framecnt_q;

endmodule

// File: doc/bubsys_framecap.md
BUBSYS_FRAMECAP -- requirements
Module: bubsys_framecap

Interface
REQ-001 SHALL have parameter H_FIRST, default 278, first captured HCOUNTER value of a line.
REQ-002 SHALL have parameter H_LAST, default 149, last captured HCOUNTER value of a line; the window wraps through 511->128 when H_FIRST > H_LAST.
REQ-003 SHALL have parameter V_FIRST, default 272, first captured VCOUNTER line.
REQ-004 SHALL have parameter V_LAST, default 495, last captured VCOUNTER line.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, pixel FIFO entries, power of 2, minimum 4.
REQ-006 SHALL have parameter EXPAND, default 1; 1 = 3 bytes/pixel BGR888, 0 = 2 bytes/pixel raw RGB555, low byte first.
REQ-007 SHALL have ports, in order:
- i_EMU_MCLK  in  1  master clock, sole clock.
- i_EMU_RST  in  1  synchronous reset, active-high.
- i_EMU_CLK6MPCEN_n  in  1  pixel clock enable, active-low.
- i_HCOUNTER  in  9  horizontal count.
- i_VCOUNTER  in  9  vertical count.
- i_VIDEODATA  in  16  pixel; [14:10]=B, [9:5]=G, [4:0]=R; bit 15 ignored.
- i_CAP_ARM  in  1  one-MCLK pulse, request capture.
- i_CAP_CONT  in  1  continuous mode (re-arm after each frame).
- o_TDATA  out  8  stream byte.
- o_TVALID  out  1  byte valid.
- i_TREADY  in  1  sink accepts byte.
- o_TUSER  out  1  start of frame, first byte only.
- o_TLAST  out  1  last byte of each line.
- o_BUSY  out  1  state != IDLE.
- o_OVERFLOW  out  1  sticky pixel-drop flag.
- o_FRAMECNT  out  16  completed frames.

Function
REQ-008 SHALL treat a pixel as "in window" when cen is low, VCOUNTER is in [V_FIRST,V_LAST], and HCOUNTER is in the (possibly wrapping) range H_FIRST..H_LAST.
REQ-009 SHALL implement FSM IDLE, WAIT_SOF, CAPTURE, DRAIN; reset state IDLE.
REQ-010 SHALL go IDLE->WAIT_SOF on i_CAP_ARM; i_CAP_ARM in any other state is ignored.
REQ-011 SHALL go WAIT_SOF->CAPTURE on the in-window pixel with V=V_FIRST, H=H_FIRST, and SHALL push that pixel tagged SOF.
REQ-012 SHALL push every in-window pixel in CAPTURE; the pixel at H=H_LAST is tagged EOL.
REQ-013 SHALL go CAPTURE->DRAIN after pushing the V=V_LAST, H=H_LAST pixel (or after attempting to push it, if dropped).
REQ-014 SHALL go DRAIN->WAIT_SOF (i_CAP_CONT=1) or DRAIN->IDLE (0) when the FIFO is empty and the last byte has been accepted; o_FRAMECNT increments (wrapping 16-bit) on that cycle.
REQ-015 FIFO entry = 15-bit colour + SOF + EOL; a push when the FIFO is full (count before the cycle, regardless of a same-cycle pop) SHALL drop the pixel and set o_OVERFLOW; o_OVERFLOW clears only on reset or an accepted i_CAP_ARM.
REQ-016 Serializer SHALL pop one entry when idle or when its final byte is accepted; EXPAND=1 emits B,G,R with each channel c expanded to {c,c[4:2]}; EXPAND=0 emits {G[2:0],R}, then {0,B,G[4:3]}.
REQ-017 o_TUSER SHALL be 1 only on the first byte of an SOF pixel; o_TLAST SHALL be 1 only on the final byte of an EOL pixel.
REQ-018 o_TDATA/o_TUSER/o_TLAST SHALL hold stable while o_TVALID=1 and i_TREADY=0; a byte transfers when both are 1.
REQ-019 Latency: a pixel pushed into an empty FIFO with an idle serializer SHALL appear on o_TVALID exactly 2 MCLK later.
REQ-020 Cen-high cycles SHALL neither push nor affect the FSM; the serializer runs every MCLK.

Reset
REQ-021 On i_EMU_RST=1 at a clock edge: state IDLE, FIFO and serializer flushed, o_TVALID=0, o_TDATA=0, o_TUSER=0, o_TLAST=0, o_BUSY=0, o_OVERFLOW=0, o_FRAMECNT=0, including mid-frame; no partial-frame bytes are emitted after reset.

Verification
REQ-022 Defaults, TREADY=1, arm once, one full frame -> 256x224 pixels, 172032 bytes, 224 TLAST pulses, 1 TUSER, FRAMECNT=1, IDLE, OVERFLOW=0.
REQ-023 Pixel 0x7FFF, EXPAND=1 -> bytes FF,FF,FF; pixel 0x4210 -> 84,84,84; EXPAND=0, pixel 0x7FFF -> FF,7F.
REQ-024 TREADY held 0 for a whole line -> FIFO fills, OVERFLOW=1, bytes stay stable while stalled; the next arm clears OVERFLOW.
REQ-025 Arm at mid-frame (V=300) -> no output until the next V=272, H=278; arm pulses during CAPTURE are ignored.
REQ-026 CONT=1 for 3 frames -> FRAMECNT=3, three TUSER pulses; reset asserted at V=400 -> TVALID=0 on the next cycle, FRAMECNT=0, IDLE.
